// File: rtl/hex_disp_pkg.sv
// Shared types and helpers for the hex display arbiter: FSM states, owner
// encodings and the leading-zero blanking mask.
package hex_disp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    // Widest display the mask helper supports; callers zero-extend narrower values.
    localparam int unsigned MAX_DIGITS = 16;

    // Bit i set when every nibble from i upward is zero; digit 0 always shown.
    function automatic logic [MAX_DIGITS-1:0] lead_zero_mask(input logic [4*MAX_DIGITS-1:0] value);
        logic [MAX_DIGITS-1:0] mask;
        logic                  seen;
        mask = '0;
        seen = 1'b0;
        for (int unsigned i = MAX_DIGITS - 1; i >= 1; i--) begin
            if (value[4*i +: 4] != 4'h0) seen = 1'b1;
            mask[i] = ~seen;
        end
        return mask;
    endfunction

endpackage

// File: rtl/hex_rr_arbiter2.sv
// Two-way round-robin grant: a lone request wins outright; on a tie the
// requester that did not win last time is granted. Purely combinational.
module hex_rr_arbiter2
    import hex_disp_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last,
    input  logic en,
    output logic gnt_a,
    output logic gnt_b
);

    assign gnt_a = en & req_a & (~req_b | (last == OWNER_B));
    assign gnt_b = en & req_b & (~req_a | (last == OWNER_A));

endmodule

// File: rtl/hex_display_arbiter.sv
// Shares the 7-segment digit bank between producer A and producer B, holding
// each granted value for HOLD_CYCLES. Define HEX_LEADING_ZERO_BLANK_EN to blank leading zeros.
module hex_display_arbiter
    import hex_disp_pkg::*;
#(
    parameter int NUM_DIGITS  = 6,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int CNT_W       = 26
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    req_a,
    input  logic [4*NUM_DIGITS-1:0] data_a,
    output logic                    ack_a,
    input  logic                    req_b,
    input  logic [4*NUM_DIGITS-1:0] data_b,
    output logic                    ack_b,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   blank,
    output logic                    owner,
    output logic                    busy
);

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [4*NUM_DIGITS-1:0] digits_q;
    logic [NUM_DIGITS-1:0]   blank_q;
    logic                    ack_a_q;
    logic                    ack_b_q;
    logic                    owner_q;
    logic                    busy_q;
    logic                    last_q;

    logic                    gnt_a;
    logic                    gnt_b;
    logic [4*NUM_DIGITS-1:0] data_d;
    logic [NUM_DIGITS-1:0]   blank_d;

    hex_rr_arbiter2 u_arb (
        .req_a (req_a),
        .req_b (req_b),
        .last  (last_q),
        .en    (state_q == IDLE),
        .gnt_a (gnt_a),
        .gnt_b (gnt_b)
    );

    assign data_d = gnt_b ? data_b : data_a;

`ifdef HEX_LEADING_ZERO_BLANK_EN
    logic [4*MAX_DIGITS-1:0] data_wide;
    logic [MAX_DIGITS-1:0]   lz_mask;
    logic                    lz_mask_unused;

    always_comb begin
        data_wide                   = '0;
        data_wide[4*NUM_DIGITS-1:0] = data_d;
        lz_mask                     = lead_zero_mask(data_wide);
        blank_d                     = lz_mask[NUM_DIGITS-1:0];
    end

    assign lz_mask_unused = &{1'b0, lz_mask};
`else
    assign blank_d = '0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            digits_q <= '0;
            blank_q  <= '1;
            ack_a_q  <= 1'b0;
            ack_b_q  <= 1'b0;
            owner_q  <= OWNER_A;
            busy_q   <= 1'b0;
            last_q   <= OWNER_B;
        end else begin
            ack_a_q <= 1'b0;
            ack_b_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (gnt_a || gnt_b) begin
                        digits_q <= data_d;
                        blank_q  <= blank_d;
                        owner_q  <= gnt_b ? OWNER_B : OWNER_A;
                        last_q   <= gnt_b ? OWNER_B : OWNER_A;
                        ack_a_q  <= gnt_a;
                        ack_b_q  <= gnt_b;
                        cnt_q    <= CNT_W'(HOLD_CYCLES - 1);
                        busy_q   <= 1'b1;
                        state_q  <= HOLD;
                    end
                end
                HOLD: begin
                    if (cnt_q == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack_a  = ack_a_q;
    assign ack_b  = ack_b_q;
    assign digits = digits_q;
    assign blank  = blank_q;
    assign owner  = owner_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Bench for hex_display_arbiter: fixed vector table, reset corner cases, random
// producers against a time-based reference model, and a HOLD_CYCLES=1 instance.
module tb_hex_display_arbiter;

    localparam int ND = 6;
    localparam int H  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          resetn;
    logic          req_a, req_b;
    logic [23:0]   data_a, data_b;
    logic          ack_a, ack_b, owner, busy;
    logic [23:0]   digits;
    logic [5:0]    blank;

    logic          req_a2;
    logic [23:0]   data_a2;
    logic          ack_a2, ack_b2, owner2, busy2;
    logic [23:0]   digits2;
    logic [5:0]    blank2;

    hex_display_arbiter #(.NUM_DIGITS(ND), .HOLD_CYCLES(H), .CNT_W(3)) dut (
        .clk(clk), .resetn(resetn),
        .req_a(req_a), .data_a(data_a), .ack_a(ack_a),
        .req_b(req_b), .data_b(data_b), .ack_b(ack_b),
        .digits(digits), .blank(blank), .owner(owner), .busy(busy)
    );

    hex_display_arbiter #(.NUM_DIGITS(ND), .HOLD_CYCLES(1), .CNT_W(1)) dut1 (
        .clk(clk), .resetn(resetn),
        .req_a(req_a2), .data_a(data_a2), .ack_a(ack_a2),
        .req_b(1'b0), .data_b(24'h0), .ack_b(ack_b2),
        .digits(digits2), .blank(blank2), .owner(owner2), .busy(busy2)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a grant is possible once the previous one's hold window has elapsed.
    int          cyc;
    int          free_at;
    logic        last;
    logic [23:0] m_dig;
    logic [5:0]  m_blank;
    logic        m_own, m_acka, m_ackb, m_busy;

    function automatic logic [5:0] ref_blank(input logic [23:0] v);
`ifdef HEX_LEADING_ZERO_BLANK_EN
        int top;
        int keep;
        top = 0;
        for (int i = 0; i < 6; i++)
            if (((v >> (4 * i)) & 24'hF) != 24'h0) top = i;
        keep = (1 << (top + 1)) - 1;
        return 6'(~keep & 63);
`else
        return 6'(v & 24'h0);
`endif
    endfunction

    task automatic model_reset();
        free_at = 0;
        last    = 1'b1;
        m_dig   = '0;
        m_blank = 6'h3F;
        m_own   = 1'b0;
        m_acka  = 1'b0;
        m_ackb  = 1'b0;
        m_busy  = 1'b0;
    endtask

    task automatic model_edge();
        logic win;
        cyc++;
        if (!resetn) begin
            model_reset();
            return;
        end
        m_acka = 1'b0;
        m_ackb = 1'b0;
        if (cyc >= free_at && (req_a || req_b)) begin
            win     = (req_a && req_b) ? ~last : req_b;
            last    = win;
            m_own   = win;
            m_dig   = win ? data_b : data_a;
            m_blank = ref_blank(m_dig);
            m_acka  = ~win;
            m_ackb  = win;
            free_at = cyc + H + 1;
        end
        m_busy = (cyc + 1 < free_at);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic cmp_model(input string tag);
        check({tag, ".ack_a"},  32'(ack_a),  32'(m_acka));
        check({tag, ".ack_b"},  32'(ack_b),  32'(m_ackb));
        check({tag, ".digits"}, 32'(digits), 32'(m_dig));
        check({tag, ".blank"},  32'(blank),  32'(m_blank));
        check({tag, ".owner"},  32'(owner),  32'(m_own));
        check({tag, ".busy"},   32'(busy),   32'(m_busy));
        check({tag, ".ack_excl"}, 32'(ack_a & ack_b), 32'(0));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".digits"}, 32'(digits), 32'(0));
        check({tag, ".blank"},  32'(blank),  32'(6'h3F));
        check({tag, ".ack_a"},  32'(ack_a),  32'(0));
        check({tag, ".ack_b"},  32'(ack_b),  32'(0));
        check({tag, ".owner"},  32'(owner),  32'(0));
        check({tag, ".busy"},   32'(busy),   32'(0));
    endtask

    function automatic logic [23:0] rnd_data();
        int          n;
        logic [23:0] v;
        n = $urandom_range(0, 6);
        v = 24'($urandom);
        if (n < 6) v = v & 24'((1 << (4 * n)) - 1);
        return v;
    endfunction

    typedef struct {
        logic        ra, rb;
        logic [23:0] da, db;
        logic        eaa, eab, eown, ebusy;
        logic [23:0] edig;
        logic [5:0]  eblank_lz;
    } vec_t;

    vec_t tbl [11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] exp_bl;
        logic [5:0] exp6;

        tbl[0]  = '{1'b1, 1'b1, 24'h00C0DE, 24'h123456, 1'b1, 1'b0, 1'b0, 1'b1, 24'h00C0DE, 6'b110000};
        tbl[1]  = '{1'b1, 1'b1, 24'h00C0DE, 24'h123456, 1'b0, 1'b0, 1'b0, 1'b1, 24'h00C0DE, 6'b110000};
        tbl[2]  = '{1'b1, 1'b1, 24'h00C0DE, 24'h123456, 1'b0, 1'b0, 1'b0, 1'b1, 24'h00C0DE, 6'b110000};
        tbl[3]  = '{1'b1, 1'b1, 24'h00C0DE, 24'h123456, 1'b0, 1'b0, 1'b0, 1'b1, 24'h00C0DE, 6'b110000};
        tbl[4]  = '{1'b1, 1'b1, 24'h00C0DE, 24'h123456, 1'b0, 1'b0, 1'b0, 1'b0, 24'h00C0DE, 6'b110000};
        tbl[5]  = '{1'b1, 1'b1, 24'h00C0DE, 24'h123456, 1'b0, 1'b1, 1'b1, 1'b1, 24'h123456, 6'b000000};
        tbl[6]  = '{1'b1, 1'b0, 24'h00C0DE, 24'h123456, 1'b0, 1'b0, 1'b1, 1'b1, 24'h123456, 6'b000000};
        tbl[7]  = '{1'b1, 1'b0, 24'h00C0DE, 24'h123456, 1'b0, 1'b0, 1'b1, 1'b1, 24'h123456, 6'b000000};
        tbl[8]  = '{1'b1, 1'b0, 24'h00C0DE, 24'h123456, 1'b0, 1'b0, 1'b1, 1'b1, 24'h123456, 6'b000000};
        tbl[9]  = '{1'b1, 1'b0, 24'h00C0DE, 24'h123456, 1'b0, 1'b0, 1'b1, 1'b0, 24'h123456, 6'b000000};
        tbl[10] = '{1'b1, 1'b1, 24'h00C0DE, 24'h123456, 1'b1, 1'b0, 1'b0, 1'b1, 24'h00C0DE, 6'b110000};

        cyc     = 0;
        resetn  = 1'b0;
        req_a   = 1'b0;
        req_b   = 1'b0;
        data_a  = '0;
        data_b  = '0;
        req_a2  = 1'b0;
        data_a2 = '0;
        model_reset();
        tick();
        tick();
        check_reset_vals("por");
        resetn = 1'b1;

        // Fixed vectors: tie after reset goes to A, then B five cycles later, then A again.
        for (int i = 0; i < 11; i++) begin
            req_a  = tbl[i].ra;
            req_b  = tbl[i].rb;
            data_a = tbl[i].da;
            data_b = tbl[i].db;
            tick();
`ifdef HEX_LEADING_ZERO_BLANK_EN
            exp_bl = tbl[i].eblank_lz;
`else
            exp_bl = 6'b000000;
`endif
            check($sformatf("vec%0d.ack_a", i),  32'(ack_a),  32'(tbl[i].eaa));
            check($sformatf("vec%0d.ack_b", i),  32'(ack_b),  32'(tbl[i].eab));
            check($sformatf("vec%0d.owner", i),  32'(owner),  32'(tbl[i].eown));
            check($sformatf("vec%0d.busy", i),   32'(busy),   32'(tbl[i].ebusy));
            check($sformatf("vec%0d.digits", i), 32'(digits), 32'(tbl[i].edig));
            check($sformatf("vec%0d.blank", i),  32'(blank),  32'(exp_bl));
        end

        // Reset in the middle of an A hold with B pending.
        req_a  = 1'b0;
        req_b  = 1'b1;
        data_b = 24'hABCDEF;
        tick();
        cmp_model("hold_pend");
        #2 resetn = 1'b0;
        #1 check_reset_vals("async_rst");
        model_reset();
        tick();
        cmp_model("rst_low1");
        tick();
        cmp_model("rst_low2");
        resetn = 1'b1;
        tick();
        check("post_rst.ack_b", 32'(ack_b), 32'(1));
        check("post_rst.digits", 32'(digits), 32'(24'hABCDEF));
        cmp_model("post_rst");

        // Random producers obeying the hold-until-ack protocol.
        for (int n = 0; n < 400; n++) begin
            tick();
            cmp_model("rand");
            if (m_acka) begin
                req_a  = 1'($urandom_range(0, 1));
                data_a = rnd_data();
            end else if (req_a) begin
                if ($urandom_range(0, 19) == 0) req_a = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                req_a  = 1'b1;
                data_a = rnd_data();
            end
            if (m_ackb) begin
                req_b  = 1'($urandom_range(0, 1));
                data_b = rnd_data();
            end else if (req_b) begin
                if ($urandom_range(0, 19) == 0) req_b = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                req_b  = 1'b1;
                data_b = rnd_data();
            end
        end
        req_a = 1'b0;
        req_b = 1'b0;

        // HOLD_CYCLES=1 instance: a held request is acked every other cycle.
`ifdef HEX_LEADING_ZERO_BLANK_EN
        exp6 = 6'b111110;
`else
        exp6 = 6'b000000;
`endif
        req_a2  = 1'b1;
        data_a2 = 24'h000000;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("h1_%0d.ack_a", k),  32'(ack_a2),  32'((k % 2) == 0));
            check($sformatf("h1_%0d.busy", k),   32'(busy2),   32'((k % 2) == 0));
            check($sformatf("h1_%0d.ack_b", k),  32'(ack_b2),  32'(0));
            check($sformatf("h1_%0d.digits", k), 32'(digits2), 32'(0));
            check($sformatf("h1_%0d.blank", k),  32'(blank2),  32'(exp6));
            check($sformatf("h1_%0d.owner", k),  32'(owner2),  32'(0));
        end
        req_a2 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
